// File: rtl/hci_core_per_timeout_bridge_if.sv
// HCI core request/response bundle and its shared width defaults.
// Used by hci_core_per_timeout_bridge on both its upstream and downstream ports.
package hci_package;
  localparam int unsigned DEFAULT_AW = 32;
  localparam int unsigned DEFAULT_DW = 32;
  localparam int unsigned DEFAULT_UW = 1;
endpackage

interface hci_core_intf #(
  parameter int unsigned AW = hci_package::DEFAULT_AW,
  parameter int unsigned DW = hci_package::DEFAULT_DW,
  parameter int unsigned UW = hci_package::DEFAULT_UW
) ();
  logic          req;
  logic          gnt;
  logic [AW-1:0] add;
  logic          wen;
  logic [DW-1:0] data;
  logic [DW/8-1:0] be;
  logic          lrdy;
  logic [UW-1:0] user;
  logic          r_valid;
  logic [DW-1:0] r_data;
  logic          r_opc;
  logic [UW-1:0] r_user;

  modport master (
    output req, add, wen, data, be, lrdy, user,
    input  gnt, r_valid, r_data, r_opc, r_user
  );

  modport slave (
    input  req, add, wen, data, be, lrdy, user,
    output gnt, r_valid, r_data, r_opc, r_user
  );
endinterface

// File: rtl/hci_core_per_timeout_bridge.sv
// Single-outstanding peripheral bridge with optional response timeout.
// Timeout logic is built only with HCI_PER_BRIDGE_TIMEOUT_EN defined.
module hci_core_per_timeout_bridge
  import hci_package::*;
#(
  parameter int unsigned AW             = DEFAULT_AW,
  parameter int unsigned DW             = DEFAULT_DW,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  hci_core_intf.slave      slave,
  hci_core_intf.master     master,
  output logic             timeout_o,
  output logic [CNT_W-1:0] timeout_cnt_o
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign master.add  = AW'(slave.add);
  assign master.wen  = slave.wen;
  assign master.data = DW'(slave.data);
  assign master.be   = slave.be;
  assign master.lrdy = slave.lrdy;
  assign master.user = slave.user;

`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
  typedef enum logic [1:0] {
    IDLE, WAIT_RSP, ERR_RSP, DRAIN
  } state_e;

  localparam int unsigned WCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WCW-1:0] LAST = WCW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] ERR_DATA = DW'(32'hbadacce5);

  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
`else
  typedef enum logic {
    IDLE, WAIT_RSP
  } state_e;
`endif

  state_e state_q, state_d;

  always_comb begin
    state_d        = state_q;
    master.req     = 1'b0;
    slave.gnt      = 1'b0;
    slave.r_valid  = 1'b0;
    slave.r_data   = '0;
    slave.r_opc    = 1'b0;
    slave.r_user   = '0;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
    wcnt_d         = wcnt_q;
    tcnt_d         = tcnt_q;
    timeout_o      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        master.req = slave.req;
        slave.gnt  = master.gnt;
        if (slave.req && master.gnt) begin
          state_d = WAIT_RSP;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end
      end
      WAIT_RSP: begin
        slave.r_valid = master.r_valid;
        slave.r_data  = master.r_data;
        slave.r_opc   = master.r_opc;
        slave.r_user  = master.r_user;
        if (master.r_valid) begin
          state_d = IDLE;
        end
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
        else begin
          // a real response on the last wait cycle wins over the timeout
          wcnt_d = wcnt_q + WCW'(1);
          if (wcnt_d == LAST) state_d = ERR_RSP;
        end
`endif
      end
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
      ERR_RSP: begin
        slave.r_valid = 1'b1;
        slave.r_data  = ERR_DATA;
        slave.r_opc   = 1'b1;
        timeout_o     = 1'b1;
        if (tcnt_q != '1) tcnt_d = tcnt_q + CNT_W'(1);
        state_d = master.r_valid ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (master.r_valid) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d = IDLE;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
      wcnt_d  = '0;
      tcnt_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
      wcnt_q  <= '0;
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
`endif
    end
  end

`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
  assign timeout_cnt_o = tcnt_q;
`else
  assign timeout_o     = 1'b0;
  assign timeout_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hci_core_per_timeout_bridge.sv
// Randomized scoreboard bench for hci_core_per_timeout_bridge.
// Expected responses come from a transaction-level timing model.
module tb_hci_core_per_timeout_bridge;
  localparam int T  = 8;
  localparam int CW = 2;
`ifdef HCI_PER_BRIDGE_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic to;
  logic [CW-1:0] tcnt;

  hci_core_intf #(.AW(32), .DW(32), .UW(4)) up ();
  hci_core_intf #(.AW(32), .DW(32), .UW(4)) dn ();

  hci_core_per_timeout_bridge #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(T), .CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .slave(up), .master(dn),
    .timeout_o(to), .timeout_cnt_o(tcnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [31:0] d;
    logic        opc;
    logic [3:0]  u;
    logic        to;
  } rsp_t;

  rsp_t sbq[$];
  int checks = 0;
  int errors = 0;
  int nto = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int sat_cnt();
    return (nto > 3) ? 3 : nto;
  endfunction

  // monitor: every forwarded response must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (up.r_valid !== 1'b0) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got r_valid=%b with nothing outstanding (cycle %0d)",
                   up.r_valid, cyc);
        end else begin
          rsp_t e;
          e = sbq.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(e.c));
          chk("rsp_data", 64'(up.r_data), 64'(e.d));
          chk("rsp_opc", 64'(up.r_opc), 64'(e.opc));
          chk("rsp_user", 64'(up.r_user), 64'(e.u));
          chk("rsp_timeout", 64'(to), 64'(e.to));
        end
      end else if (to !== 1'b0) begin
        chk("timeout_without_rvalid", 64'(to), 64'(0));
      end
    end
  end

  task automatic drive_idle_defaults();
    up.req = 1'b0; up.add = '0; up.wen = 1'b0; up.data = '0;
    up.be = '0; up.lrdy = 1'b1; up.user = '0;
    dn.gnt = 1'b0; dn.r_valid = 1'b0; dn.r_data = '0;
    dn.r_opc = 1'b0; dn.r_user = '0;
  endtask

  // called at posedge+1; returns at posedge+1 of the cycle after the response
  task automatic txn(int L, logic [31:0] rd, logic op);
    logic [31:0] a;
    logic [3:0]  ru;
    int g;
    a  = $urandom;
    ru = 4'($urandom);
    g  = cyc;
    up.req = 1'b1; up.add = a; up.wen = 1'($urandom);
    up.data = $urandom; up.be = 4'($urandom); up.user = 4'($urandom);
    dn.gnt = 1'b1;
    @(negedge clk);
    chk("grant_req", 64'(dn.req), 64'(1));
    chk("grant_gnt", 64'(up.gnt), 64'(1));
    chk("add_pass", 64'(dn.add), 64'(a));
    chk("timeout_cnt", 64'(tcnt), 64'(sat_cnt()));
    if (TEN && L >= T) begin
      sbq.push_back('{g + T, 32'hbadacce5, 1'b1, 4'h0, 1'b1});
      nto++;
    end else begin
      sbq.push_back('{g + L, rd, op, ru, 1'b0});
    end
    for (int k = 1; k <= L; k++) begin
      @(posedge clk); #1;
      up.req = 1'($urandom_range(0, 1));
      dn.gnt = 1'b1;
      if (k == L) begin
        dn.r_valid = 1'b1; dn.r_data = rd;
        dn.r_opc = op; dn.r_user = ru;
      end
      @(negedge clk);
      chk("busy_req", 64'(dn.req), 64'(0));
      chk("busy_gnt", 64'(up.gnt), 64'(0));
    end
    @(posedge clk); #1;
    dn.r_valid = 1'b0; up.req = 1'b0; dn.gnt = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      up.req = 1'($urandom_range(0, 1));
      dn.gnt = 1'b0;
      dn.r_valid = 1'($urandom_range(0, 1));
      dn.r_data = $urandom;
      @(negedge clk);
      chk("idle_req", 64'(dn.req), 64'(up.req));
      @(posedge clk); #1;
    end
    up.req = 1'b0; dn.r_valid = 1'b0;
  endtask

  task automatic clear_txn();
    up.req = 1'b1; dn.gnt = 1'b1; up.add = $urandom;
    @(negedge clk);
    chk("clr_grant", 64'(up.gnt), 64'(1));
    @(posedge clk); #1;
    up.req = 1'b0; dn.gnt = 1'b0;
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; up.req = 1'b1; dn.gnt = 1'b0;
    nto = 0;
    @(negedge clk);
    chk("clr_idle_req", 64'(dn.req), 64'(1));
    chk("clr_idle_gnt", 64'(up.gnt), 64'(0));
    chk("clr_cnt", 64'(tcnt), 64'(0));
    @(posedge clk); #1;
    up.req = 1'b0; dn.r_valid = 1'b1; dn.r_data = $urandom;
    @(posedge clk); #1;
    dn.r_valid = 1'b0;
  endtask

  initial begin
    drive_idle_defaults();
    up.req = 1'b1;
    @(negedge clk);
    chk("rst_rvalid", 64'(up.r_valid), 64'(0));
    chk("rst_rdata", 64'(up.r_data), 64'(0));
    chk("rst_ropc", 64'(up.r_opc), 64'(0));
    chk("rst_ruser", 64'(up.r_user), 64'(0));
    chk("rst_timeout", 64'(to), 64'(0));
    chk("rst_cnt", 64'(tcnt), 64'(0));
    chk("rst_req_pass", 64'(dn.req), 64'(1));
    chk("rst_gnt_pass", 64'(up.gnt), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; up.req = 1'b0;
    @(posedge clk); #1;

    txn(3, 32'h12345678, 1'b0);
    txn(2, $urandom, 1'b1);
    txn(T - 1, $urandom, 1'b0);
    txn(12, $urandom, 1'b0);
    txn(T, $urandom, 1'b1);
    txn(9, $urandom, 1'b0);
    txn(T + 2, $urandom, 1'b0);
    txn(T, $urandom, 1'b0);
    idle(2);
    clear_txn();
    txn(4, $urandom, 1'b1);

    repeat (80) begin
      int r;
      r = $urandom_range(0, 11);
      if (r == 0) clear_txn();
      else if (r == 1) idle($urandom_range(1, 3));
      else txn($urandom_range(1, 14), $urandom, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    chk("sb_drained", 64'(sbq.size()), 64'(0));
    chk("final_cnt", 64'(tcnt), 64'(sat_cnt()));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
endmodule
